// File: rtl/fir_decim_pkg.sv
// rtl/fir_decim_pkg.sv - default widths, sizing helpers and saturation for fir_decim_out
package fir_decim_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_OUT_W  = 8;
    localparam int DEF_DECIM  = 4;
    localparam int DEF_SHIFT  = 2;
    localparam int DEF_DEPTH  = 4;

    // Arithmetic is carried at this width so the rounding add never wraps
    localparam int CALC_W = 32;

    function automatic int log2c(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic logic [CALC_W-1:0] round_const(input int s);
        return (s > 0) ? (CALC_W'(1) << (s - 1)) : '0;
    endfunction

    function automatic logic [CALC_W-1:0] saturate(input logic [CALC_W-1:0] r, input int out_w);
        logic [CALC_W-1:0] lim;
        lim = (CALC_W'(1) << out_w) - CALC_W'(1);
        return (r > lim) ? lim : r;
    endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// rtl/fir_decim_out_if.sv - valid/ready sample stream between fir_decim_out and its consumer
interface fir_decim_out_if #(
    parameter int OUT_W = 8
);
    logic             valid;
    logic             ready;
    logic [OUT_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_decim_out_fifo.sv
// rtl/fir_decim_out_fifo.sv - sync_fifo: small synchronous FIFO; a push while full is kept only with a same-cycle pop
module sync_fifo
    import fir_decim_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [ptr_w(DEPTH):0] count
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fir_decim_out.sv
// rtl/fir_decim_out.sv - decimate, round, shift and saturate FIR samples into a buffered valid/ready stream
// DECIM_AVG_EN: average each DECIM-sample window instead of picking its last sample.
module fir_decim_out
    import fir_decim_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int DECIM  = DEF_DECIM,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [DATA_W-1:0] y_in,
    fir_decim_out_if.master   m,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int LOG2D = log2c(DECIM);
    localparam int PH_W  = (LOG2D > 0) ? LOG2D : 1;
`ifdef DECIM_AVG_EN
    localparam int TOT_SHIFT = SHIFT + LOG2D;
`else
    localparam int TOT_SHIFT = SHIFT;
`endif
    localparam logic [CALC_W-1:0] RND  = round_const(TOT_SHIFT);
    localparam logic [PH_W-1:0]   LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]        phase;
    logic                   capture;
    logic [CALC_W-1:0]      pre;
    logic [OUT_W-1:0]       stage_next;
    logic                   stage_valid;
    logic [OUT_W-1:0]       stage_data;
    logic [OUT_W-1:0]       head;
    logic                   full;
    logic                   empty;
    logic [ptr_w(DEPTH):0]  fifo_count;
    logic                   pop;
    logic                   drop;

    assign capture = in_en && (phase == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        phase <= '0;
        else if (in_en) phase <= capture ? '0 : phase + 1'b1;
    end

`ifdef DECIM_AVG_EN
    localparam int ACC_W = DATA_W + LOG2D;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_sum;

    // Window restarts at phase 0, so the stale sum is discarded there
    assign acc_base = (phase == '0) ? '0 : acc;
    assign acc_sum  = acc_base + ACC_W'(y_in);
    assign pre      = CALC_W'(acc_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        acc <= '0;
        else if (in_en) acc <= acc_sum;
    end
`else
    assign pre = CALC_W'(y_in);
`endif

    assign stage_next = OUT_W'(saturate((pre + RND) >> TOT_SHIFT, OUT_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            stage_valid <= capture;
            if (capture) stage_data <= stage_next;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stage_valid),
        .push_data (stage_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign m.valid = (fifo_count != '0);
    assign m.data  = empty ? '0 : head;
    assign pop     = m.valid && m.ready;
    assign drop    = stage_valid && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end
endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
Downstream stage of the 3-tap FIR. Consumes the FIR's 16-bit unsigned output stream and decimates by DECIM. Each kept sample is rounded, right-shifted and saturated to OUT_W bits. Results are buffered in a small FIFO and presented on a valid/ready master interface to the consumer, with a sticky overflow flag when samples are dropped.

Parameters:
DATA_W, 16, input sample width (unsigned; matches FIR output)
OUT_W, 8, output sample width (unsigned)
DECIM, 4, decimation ratio, >=1; power of 2 when DECIM_AVG_EN is defined
SHIFT, 2, right-shift applied before saturation, 0..DATA_W-1
DEPTH, 4, FIFO depth in entries, power of 2, >=2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_en  in  1  y_in holds a valid FIR sample this cycle; tie to 1 for a free-running FIR
y_in  in  DATA_W  FIR output sample
m_valid  out  1  m_data holds a valid output sample
m_ready  in  1  consumer accepts m_data this cycle
m_data  out  OUT_W  FIFO head sample; 0 whenever m_valid=0
overflow  out  1  sticky: a decimated sample was dropped because the FIFO was full
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, immediate): phase counter=0, stage register empty, FIFO empty, m_valid=0, m_data=0, overflow=0.
- Phase counter counts 0..DECIM-1 on each in_en=1 cycle and wraps to 0. It holds when in_en=0.
- Capture: at the edge where in_en=1 and phase==DECIM-1 (edge T), y_in is processed and loaded into the stage register.
  - With DECIM=1, every in_en sample is captured.
- Arithmetic (edge T):
  - r = (y_in + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed at DATA_W+1 bits with no wrap.
  - If r > 2^OUT_W-1, the result is 2^OUT_W-1; otherwise it is r[OUT_W-1:0].
- Push: at edge T+1 the stage value is written into the FIFO. m_valid is visible after edge T+1, so latency is 2 clocks from the sample at the input to m_valid, when the FIFO is empty.
- Handshake:
  - A pop occurs at an edge with m_valid=1 and m_ready=1.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
  - Samples come out in FIFO order.
- Full, no pop: the push is dropped, FIFO contents are unchanged, and overflow is set at that edge.
- Full with a simultaneous pop: the push is accepted and overflow is not set.
- Empty: m_valid=0 and m_data=0. A pop is impossible. A simultaneous push makes m_valid=1 next cycle.
- Counts: the FIFO count ranges 0..DEPTH. Pointers wrap modulo DEPTH.
- clr_ovf=1 clears overflow at the next edge. If an overflow event occurs in the same cycle, set wins.
- Reset mid-operation: all buffered and in-flight samples are discarded. After release, the first capture is the DECIM-th in_en cycle.

Optional Feature:
Macro DECIM_AVG_EN.
- Defined:
  - Block averages instead of picking: an accumulator of width DATA_W+log2(DECIM) sums all DECIM in_en samples of a phase window, clearing at the window start.
  - At the capture edge, the full sum (including the current y_in) is rounded and shifted by SHIFT+log2(DECIM), with rounding constant 2^(SHIFT+log2(DECIM)-1), then saturated as above.
- Undefined: plain pick-every-DECIM-th sample; no accumulator is present.
- Latency and handshake are identical in both builds.

Decomposition:
- Package fir_decim_pkg holds:
  - the default widths;
  - localparam helpers for log2(DECIM), FIFO pointer width and the rounding constant;
  - a saturate function.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push/pop/full/empty/count.
  - A push while full is ignored, unless a pop occurs in the same cycle.
  - The top level owns the phase counter, the arithmetic stage, overflow, and m_data zero-masking.

Test Plan:
1. Reset: assert rst mid-stream with the FIFO holding 3 entries -> m_valid=0, m_data=0 and overflow=0 immediately. After release with in_en=1, the first m_valid occurs 2 cycles after the 4th input sample.
2. Ramp y_in=0,1,2,... with in_en=1, m_ready=1 (DECIM=4, SHIFT=2) -> captured samples 3,7,11,15 -> m_data=1,2,3,4, each m_valid pulse 1 cycle wide.
3. Saturation: y_in=16'hFFFF -> m_data=255; y_in=1021 -> 255; y_in=1022 -> 255; y_in=1017 -> 254.
4. Backpressure: m_ready=0 for 5 decimated samples -> 4 stored, 5th dropped, overflow=1. Then m_ready=1 drains the 4 in order and m_valid falls. clr_ovf pulse -> overflow=0. clr_ovf coinciding with a drop -> overflow stays 1.
5. Full FIFO with m_ready=1 on the push edge -> push accepted, overflow stays 0, count stays 4.
6. DECIM_AVG_EN build: constant y_in=10 -> sum 40 -> (40+8)>>4 = 3. Gapped in_en (1,0,1,0,...) -> the window closes only after 4 enabled samples.
